// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding feeding the ALU.
// Forwarding muxes are built only when EX_OPERAND_FWD_EN is defined; otherwise operands bypass.
module id_ex_operand_stage #(
  parameter int unsigned       DATA_W  = 32,
  parameter int unsigned       REG_AW  = 5,
  parameter int unsigned       CTRL_W  = 5,
  parameter logic [CTRL_W-1:0] ALU_ADD = CTRL_W'(2)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_write_reg,
  input  logic [CTRL_W-1:0] id_alu_control,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_write_reg,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_write_reg,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] src_a,
  output logic [DATA_W-1:0] src_b,
  output logic [CTRL_W-1:0] sig_alu_control,
  output logic [DATA_W-1:0] ex_write_data,
  output logic [REG_AW-1:0] ex_write_reg,
  output logic              ex_reg_write,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg
);

  typedef struct packed {
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] write_reg;
    logic [CTRL_W-1:0] alu_control;
    logic              alu_src;
    logic              reg_write;
    logic              mem_write;
    logic              mem_to_reg;
  } stage_t;

  stage_t stage_d, stage_q;
  stage_t bubble;

  // Bubble is an add of 0+0 with every side-effect control cleared.
  always_comb begin
    bubble             = '0;
    bubble.alu_control = ALU_ADD;
  end

  always_comb begin
    stage_d = stage_q;
    if (reset || flush) begin
      stage_d = bubble;
    end else if (!stall) begin
      stage_d.rd1         = id_rd1;
      stage_d.rd2         = id_rd2;
      stage_d.imm         = id_imm;
      stage_d.rs          = id_rs;
      stage_d.rt          = id_rt;
      stage_d.write_reg   = id_write_reg;
      stage_d.alu_control = id_alu_control;
      stage_d.alu_src     = id_alu_src;
      stage_d.reg_write   = id_reg_write;
      stage_d.mem_write   = id_mem_write;
      stage_d.mem_to_reg  = id_mem_to_reg;
    end
  end

  always_ff @(posedge clk) begin
    stage_q <= stage_d;
  end

  logic [DATA_W-1:0] fwd_a, fwd_b;

`ifdef EX_OPERAND_FWD_EN
  // MEM is the younger producer, so it takes precedence over WB; r0 is never forwarded.
  always_comb begin
    fwd_a = stage_q.rd1;
    if (mem_reg_write && (mem_write_reg == stage_q.rs) && (stage_q.rs != '0)) begin
      fwd_a = mem_alu_result;
    end else if (wb_reg_write && (wb_write_reg == stage_q.rs) && (stage_q.rs != '0)) begin
      fwd_a = wb_result;
    end
  end

  always_comb begin
    fwd_b = stage_q.rd2;
    if (mem_reg_write && (mem_write_reg == stage_q.rt) && (stage_q.rt != '0)) begin
      fwd_b = mem_alu_result;
    end else if (wb_reg_write && (wb_write_reg == stage_q.rt) && (stage_q.rt != '0)) begin
      fwd_b = wb_result;
    end
  end
`else
  always_comb begin
    fwd_a = stage_q.rd1;
    fwd_b = stage_q.rd2;
  end

  // Forwarding inputs are kept on the port list for drop-in compatibility.
  logic unused_fwd;
  assign unused_fwd = ^{mem_reg_write, mem_write_reg, mem_alu_result,
                        wb_reg_write, wb_write_reg, wb_result, stage_q.rs, stage_q.rt};
`endif

  always_comb begin
    src_a           = fwd_a;
    src_b           = stage_q.alu_src ? stage_q.imm : fwd_b;
    ex_write_data   = fwd_b;
    sig_alu_control = stage_q.alu_control;
    ex_write_reg    = stage_q.write_reg;
    ex_reg_write    = stage_q.reg_write;
    ex_mem_write    = stage_q.mem_write;
    ex_mem_to_reg   = stage_q.mem_to_reg;
  end

endmodule
